data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/sp_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// memory-mapped register addresses and the error read-back value.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  // Which decoded target a request hits.
  typedef enum logic [1:0] {
    T_RAM,
    T_LED,
    T_CYC,
    T_ERR
  } target_t;

  localparam logic [31:0] LED_ADDR   = 32'h0000_0080;
  localparam logic [31:0] CYCLE_ADDR = 32'h0000_0084;
  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/sp_ram.sv
// Synchronous single-port RAM with write-enable and a registered read port.
// A read issued in one cycle presents its data on rdata the following cycle.
module sp_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and its read register have no reset, so the block maps
  // onto a vendor RAM and stored contents survive a system reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for a simple core: word RAM, an LED register and a
// free-running cycle counter, one outstanding request at a time.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LED_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [LED_W-1:0] led,
  output logic             addr_err
);

  localparam logic [31:0] RAM_BYTES = 32'(4 * (2 ** ADDR_W));

  state_t      state, state_nxt;
  target_t     tgt;
  logic        accept;
  logic        ram_en, ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] cycle_q;
  logic [31:0] rdata_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tgt = T_ERR;
    if (req_addr[1:0] == 2'b00) begin
      if (req_addr < RAM_BYTES)        tgt = T_RAM;
      else if (req_addr == LED_ADDR)   tgt = T_LED;
      else if (req_addr == CYCLE_ADDR) tgt = T_CYC;
    end
  end

  assign accept = req_valid && (state == IDLE);
  assign ram_en = accept && (tgt == T_RAM);
  assign ram_we = ram_en && req_write;

  sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (req_addr[ADDR_W+1:2]),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          // Only RAM loads need the extra cycle for the registered read.
          state_nxt = (tgt == T_RAM && !req_write) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cycle_q  <= '0;
      rdata_q  <= '0;
      led      <= '0;
      addr_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cycle_q <= cycle_q + 32'd1;
      if (accept) begin
        case (tgt)
          T_RAM: rdata_q <= '0;
          T_LED: begin
            if (req_write) led <= req_wdata[LED_W-1:0];
            rdata_q <= req_write ? 32'd0 : 32'(led);
          end
          T_CYC: rdata_q <= req_write ? 32'd0 : cycle_q;
          default: begin
            addr_err <= 1'b1;
            rdata_q  <= req_write ? 32'd0 : ERR_DATA;
          end
        endcase
      end
      if (state == RD_WAIT) begin
        rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic compared against an address-map level reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  led;
  logic        addr_err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state.
  logic [31:0] mem_m [32];
  logic [7:0]  led_m;
  logic        err_m;
  time         t_rel;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(5), .LED_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .led      (led),
    .addr_err (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rising edges since reset release, read on a falling edge.
  function automatic logic [31:0] cycles_now();
    return 32'(($time - t_rel) / 10);
  endfunction

  // Applies one accepted request to the model; returns expected data and latency.
  task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] exp_d, output int exp_lat);
    exp_d   = 32'd0;
    exp_lat = 1;
    if (a % 4 != 0) begin
      err_m = 1'b1;
      if (!w) exp_d = 32'hDEAD_BEEF;
    end else if (a < 128) begin
      if (w) mem_m[a / 4] = d;
      else begin
        exp_d   = mem_m[a / 4];
        exp_lat = 2;
      end
    end else if (a == 32'h80) begin
      if (w) led_m = d[7:0];
      else exp_d = {24'd0, led_m};
    end else if (a == 32'h84) begin
      if (!w) exp_d = cycles_now();
    end else begin
      err_m = 1'b1;
      if (!w) exp_d = 32'hDEAD_BEEF;
    end
  endtask

  // One isolated request: present, wait for accept, wait (bounded) for the pulse.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] got);
    logic [31:0] exp_d;
    int exp_lat, lat;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("accept_ready", req_ready, 1);
    predict(w, a, d, exp_d, exp_lat);
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      check("busy_not_ready", req_ready, 0);
      if (rsp_valid) seen = 1;
      else check("idle_rdata_zero", rsp_rdata, 0);
    end
    check("latency", lat, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_d);
    check("led", led, led_m);
    check("addr_err", addr_err, err_m);
    got = rsp_rdata;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  initial begin
    logic [31:0] got, v1, v2;
    req_t        items [$];
    logic [31:0] exp_d;
    int          exp_lat, acc_n, idx, pulses, accepts;
    bit          outstanding;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    led_m = '0; err_m = 1'b0; t_rel = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_led", led, 0);
    check("rst_err", addr_err, 0);
    reset = 1'b0;
    t_rel = $time;

    // Fill the RAM so every word has a known value.
    for (int i = 0; i < 32; i++) xact(1'b1, 32'(i * 4), $urandom, got);

    // Store then load the same RAM word.
    xact(1'b1, 32'h08, 32'h1234_5678, got);
    xact(1'b0, 32'h08, 32'h0, got);
    check("ram_readback", got, 32'h1234_5678);

    // LED register.
    xact(1'b1, 32'h80, 32'h0000_01A5, got);
    check("led_value", led, 32'hA5);
    xact(1'b0, 32'h80, 32'h0, got);
    check("led_readback", got, 32'h0000_00A5);

    // Cycle counter: accepts exactly 10 cycles apart.
    xact(1'b0, 32'h84, 32'h0, v1);
    repeat (8) @(negedge clk);
    xact(1'b0, 32'h84, 32'h0, v2);
    check("cycle_delta", v2 - v1, 32'd10);

    // Illegal accesses: out of range load, misaligned store.
    xact(1'b0, 32'h100, 32'h0, got);
    check("err_data", got, 32'hDEAD_BEEF);
    check("err_set", addr_err, 1);
    xact(1'b1, 32'h06, 32'hFFFF_FFFF, got);
    xact(1'b0, 32'h04, 32'h0, got);
    check("word1_unchanged", got, mem_m[1]);
    check("err_sticky", addr_err, 1);

    // Random traffic over the whole address map.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: a = 32'($urandom_range(0, 31) * 4);
        2:    a = 32'h80;
        3:    a = 32'h84;
        4:    a = 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
        default: a = 32'h100 + 32'($urandom_range(0, 1000) * 4);
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom, got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while a RAM load sits in RD_WAIT.
    xact(1'b1, 32'h0C, 32'hCAFE_F00D, got);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C;
    check("pre_rst_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_err", addr_err, 0);
    @(negedge clk);
    reset = 1'b0;
    t_rel = $time;
    led_m = '0;
    err_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    xact(1'b0, 32'h0C, 32'h0, got);
    check("ram_survives_reset", got, 32'hCAFE_F00D);
    xact(1'b0, 32'h84, 32'h0, got);

    // Back-to-back traffic with req_valid never dropping.
    for (int i = 0; i < 10; i++) begin
      req_t r;
      r.w = 1'($urandom_range(0, 1));
      r.a = (i % 3 == 2) ? 32'h84 : 32'($urandom_range(0, 31) * 4);
      r.d = $urandom;
      items.push_back(r);
    end
    idx = 0; pulses = 0; accepts = 0; outstanding = 0; acc_n = 0;
    exp_d = '0; exp_lat = 0;
    req_valid = 1'b1;
    req_write = items[0].w; req_addr = items[0].a; req_wdata = items[0].d;
    for (int n = 0; n < 100 && (idx < items.size() || outstanding); n++) begin
      @(negedge clk);
      check("stream_ready", req_ready, !outstanding);
      if (rsp_valid) begin
        check("stream_pulse_expected", outstanding, 1);
        check("stream_rdata", rsp_rdata, exp_d);
        check("stream_latency", n - acc_n, exp_lat);
        outstanding = 0;
        pulses++;
      end
      if (!outstanding && req_ready && idx < items.size()) begin
        req_write = items[idx].w; req_addr = items[idx].a; req_wdata = items[idx].d;
        predict(items[idx].w, items[idx].a, items[idx].d, exp_d, exp_lat);
        outstanding = 1;
        acc_n = n;
        accepts++;
        idx++;
      end
    end
    req_valid = 1'b0;
    check("stream_accepts", accepts, items.size());
    check("stream_pulses", pulses, items.size());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_no_dup", rsp_valid, 0);
    end
    for (int i = 0; i < 32; i++) begin
      xact(1'b0, 32'(i * 4), 32'h0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
